// File: rtl/acq_multich_ctrl.sv
// Multi-channel ADC window capture: decimates the ADC strobe and serialises each kept
// N_CH-wide sample into consecutive 32-bit BRAM writes, interleaved by channel.
module acq_multich_ctrl #(
    parameter int DATA_W = 14,
    parameter int N_CH   = 2,
    parameter int LEN_W  = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [LEN_W-1:0]       i_window_len,
    input  logic [7:0]             i_decim,
    input  logic                   i_valid,
    input  logic [N_CH*DATA_W-1:0] i_data,
    output logic [3:0]             o_bram_we,
    output logic [31:0]            o_bram_data,
    output logic [31:0]            o_bram_addr,
    output logic                   o_bram_en,
    output logic                   o_bram_rst,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overrun,
    output logic                   o_frame_start
);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

    state_t                  state_reg;
    logic                    start_q_reg;
    logic [LEN_W-1:0]        len_reg;
    logic [LEN_W-1:0]        idx_reg;
    logic [7:0]              decim_reg;
    logic [7:0]              dcnt_reg;
    logic [N_CH*DATA_W-1:0]  hold_reg;
    logic [2:0]              wr_ch_reg;

    logic start_edge;
    logic kept;
    logic wr_active;
    logic last_ch;

    assign start_edge = i_start & ~start_q_reg;
    assign kept       = i_valid & (dcnt_reg == 8'd0);
    // The serialiser is busy exactly while a write is on the outputs.
    assign wr_active  = (o_bram_we == 4'hF);
    assign last_ch    = (wr_ch_reg == 3'(N_CH - 1));

    assign o_bram_en  = 1'b1;
    assign o_bram_rst = ~rstn;

    function automatic logic [31:0] sext(input logic [DATA_W-1:0] s);
        logic signed [DATA_W-1:0] t;
        t = s;
        return 32'(t);
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            start_q_reg   <= 1'b0;
            len_reg       <= '0;
            idx_reg       <= '0;
            decim_reg     <= 8'd0;
            dcnt_reg      <= 8'd0;
            hold_reg      <= '0;
            wr_ch_reg     <= 3'd0;
            o_bram_we     <= 4'h0;
            o_bram_data   <= 32'd0;
            o_bram_addr   <= 32'd0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_overrun     <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            start_q_reg   <= i_start;
            o_frame_start <= 1'b0;
            case (state_reg)
                ST_CAPTURE: begin
                    if (i_abort) begin
                        state_reg <= ST_IDLE;
                        o_busy    <= 1'b0;
                        o_bram_we <= 4'h0;
                    end else if (len_reg == '0) begin
                        state_reg <= ST_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        if (i_valid) begin
                            dcnt_reg <= (dcnt_reg == decim_reg) ? 8'd0 : dcnt_reg + 8'd1;
                        end
                        if (wr_active) begin
                            if (kept) begin
                                o_overrun <= 1'b1;
                            end
                            if (last_ch) begin
                                o_bram_we <= 4'h0;
                                idx_reg   <= idx_reg + 1'b1;
                                if (idx_reg == len_reg - 1'b1) begin
                                    state_reg <= ST_DONE;
                                    o_busy    <= 1'b0;
                                    o_done    <= 1'b1;
                                end
                            end else begin
                                // Remaining channels shift down out of the holding register.
                                wr_ch_reg   <= wr_ch_reg + 3'd1;
                                o_bram_addr <= o_bram_addr + 32'd4;
                                o_bram_data <= sext(hold_reg[DATA_W-1:0]);
                                hold_reg    <= hold_reg >> DATA_W;
                            end
                        end else if (kept) begin
                            o_bram_we     <= 4'hF;
                            wr_ch_reg     <= 3'd0;
                            o_bram_addr   <= 32'(idx_reg) * 32'(N_CH * 4);
                            o_bram_data   <= sext(i_data[DATA_W-1:0]);
                            hold_reg      <= i_data >> DATA_W;
                            o_frame_start <= (idx_reg == '0);
                        end
                    end
                end
                default: begin
                    if (start_edge && !i_abort) begin
                        state_reg <= ST_CAPTURE;
                        o_busy    <= 1'b1;
                        o_done    <= 1'b0;
                        o_overrun <= 1'b0;
                        len_reg   <= i_window_len;
                        decim_reg <= i_decim;
                        idx_reg   <= '0;
                        dcnt_reg  <= 8'd0;
                        wr_ch_reg <= 3'd0;
                        o_bram_we <= 4'h0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_multich_ctrl.sv
// Randomised bench for acq_multich_ctrl: a window-level reference model queues the
// expected BRAM writes, and a monitor checks every write the DUT presents.
module tb_acq_multich_ctrl;

    localparam int DATA_W = 14;
    localparam int N_CH   = 2;
    localparam int LEN_W  = 10;
    localparam int DW     = N_CH * DATA_W;
    localparam int NEVER  = 1 << 30;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [LEN_W-1:0] i_window_len = '0;
    logic [7:0]       i_decim = 8'd0;
    logic             i_valid = 1'b0;
    logic [DW-1:0]    i_data = '0;
    logic [3:0]       o_bram_we;
    logic [31:0]      o_bram_data;
    logic [31:0]      o_bram_addr;
    logic             o_bram_en;
    logic             o_bram_rst;
    logic             o_busy;
    logic             o_done;
    logic             o_overrun;
    logic             o_frame_start;

    acq_multich_ctrl #(.DATA_W(DATA_W), .N_CH(N_CH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_abort(i_abort),
        .i_window_len(i_window_len), .i_decim(i_decim), .i_valid(i_valid), .i_data(i_data),
        .o_bram_we(o_bram_we), .o_bram_data(o_bram_data), .o_bram_addr(o_bram_addr),
        .o_bram_en(o_bram_en), .o_bram_rst(o_bram_rst), .o_busy(o_busy), .o_done(o_done),
        .o_overrun(o_overrun), .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        bit          fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (o_bram_we != 4'h0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", o_bram_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_we", o_bram_we, 4'hF);
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", o_bram_addr, e.addr);
                check("wr_data", o_bram_data, e.data);
                check("wr_frame_start", o_frame_start, e.fs);
                $display("write cyc=%0d addr=%0h data=%08h fs=%0d", cyc, o_bram_addr, o_bram_data, o_frame_start);
            end
        end else if (o_frame_start) begin
            check("frame_start_without_write", o_frame_start, 0);
        end
    end

    function automatic logic [31:0] sext_ref(input logic [DATA_W-1:0] v);
        return {{(32 - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // period: valid every period-th cycle; 0 = random strobe.
    // kill_mode: 0 none, 1 abort, 2 reset, applied kill_off cycles into the capture.
    task automatic run_window(input int len, input int decim, input int period,
                              input int kill_mode, input int kill_off, input bit restart);
        int   s, c, vcount, accepted, next_free, end_c, kill_c;
        bit   ov, finished, kept;
        exp_t e;
        logic [DATA_W-1:0] chv;
        @(posedge clk); #1;
        i_start = 1'b0; i_valid = 1'b0;
        @(posedge clk); #1;
        s = cyc;
        i_start = 1'b1; i_window_len = LEN_W'(len); i_decim = 8'(decim);
        i_data = DW'($urandom);
        vcount = 0; accepted = 0; next_free = 0; ov = 0; finished = 0;
        end_c  = (len == 0) ? s + 1 : NEVER;
        kill_c = (kill_mode != 0) ? s + 1 + kill_off : NEVER;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            c = cyc;
            if (restart) begin
                if (c <= end_c && c <= kill_c) i_start = 1'($urandom_range(0, 1));
            end else begin
                i_start = 1'b0;
            end
            i_valid = (period == 0) ? 1'($urandom_range(0, 1)) : ((c - s - 1) % period == 0);
            i_data  = DW'($urandom);
            i_abort = (kill_mode == 1 && c == kill_c);
            rstn    = !(kill_mode == 2 && c == kill_c);
            if (i_valid && len != 0 && c <= end_c && c < kill_c) begin
                kept = (vcount % (decim + 1)) == 0;
                vcount++;
                if (kept) begin
                    if (c < next_free) begin
                        ov = 1;
                    end else begin
                        for (int k = 0; k < N_CH; k++) begin
                            chv    = i_data[k*DATA_W +: DATA_W];
                            e.cyc  = c + 1 + k;
                            e.addr = 32'((accepted * N_CH + k) * 4);
                            e.data = sext_ref(chv);
                            e.fs   = (accepted == 0 && k == 0);
                            if (e.cyc <= kill_c) exp_q.push_back(e);
                        end
                        accepted++;
                        next_free = c + N_CH + 1;
                        if (accepted == len) end_c = c + N_CH;
                    end
                end
            end
            @(negedge clk);
            if (kill_c != NEVER && c == kill_c + 1) begin
                check("kill_we", o_bram_we, 0);
                check("kill_busy", o_busy, 0);
                check("kill_done", o_done, 0);
                check("kill_overrun", o_overrun, (kill_mode == 1) ? ov : 1'b0);
                if (kill_mode == 2) begin
                    check("rst_mid_addr", o_bram_addr, 0);
                    check("rst_mid_data", o_bram_data, 0);
                    check("rst_mid_fs", o_frame_start, 0);
                end
                finished = 1;
                break;
            end
            if (end_c < kill_c && c == end_c) begin
                check("pre_done", o_done, 0);
                check("pre_busy", o_busy, 1);
            end
            if (end_c < kill_c && c == end_c + 1) begin
                check("done", o_done, 1);
                check("done_busy", o_busy, 0);
                check("done_overrun", o_overrun, ov);
                finished = 1;
                break;
            end
        end
        if (!finished) check("window_timeout", 0, 1);
        $display("window len=%0d decim=%0d period=%0d kill=%0d accepted=%0d overrun=%0d",
                 len, decim, period, kill_mode, accepted, ov);
        i_valid = 1'b0;
        i_abort = 1'b0;
        rstn    = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            i_valid = ~i_valid;
            i_data  = DW'($urandom);
            @(negedge clk);
            check("rst_we", o_bram_we, 0);
            check("rst_addr", o_bram_addr, 0);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
        end
        check("bram_rst_in_reset", o_bram_rst, 1);
        @(posedge clk); #1;
        rstn = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        check("bram_rst_released", o_bram_rst, 0);
        check("bram_en", o_bram_en, 1);

        run_window(4, 0, 3, 0, 0, 0);   // basic interleave
        run_window(3, 2, 4, 0, 0, 0);   // decimation
        run_window(5, 0, 1, 0, 0, 0);   // overrun at full strobe rate
        run_window(3, 0, 5, 0, 0, 0);   // start from DONE clears overrun
        run_window(8, 0, 3, 1, 4, 0);   // abort after 3 writes
        run_window(3, 0, 3, 0, 0, 0);   // addresses restart at 0
        run_window(6, 1, 2, 0, 0, 1);   // start re-pulsed mid-capture
        run_window(0, 0, 1, 0, 0, 0);   // empty window
        run_window(6, 0, 3, 2, 7, 0);   // reset mid-capture
        run_window(2, 0, 3, 0, 0, 0);
        for (int w = 0; w < 8; w++) begin
            run_window($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(0, 5),
                       0, 0, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
